// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester and ALU signals of the shared-ALU arbiter.
// The arbiter uses the slave view; requesters plus the external ALU use the master view.
interface alu_arbiter_if #(
   parameter int unsigned W = 32
);
   // Requester side
   logic         req0;
   logic         req1;
   logic [3:0]   f0;
   logic [3:0]   f1;
   logic [W-1:0] a0;
   logic [W-1:0] a1;
   logic [W-1:0] b0;
   logic [W-1:0] b1;
   logic         gnt0;
   logic         gnt1;
   logic         done0;
   logic         done1;
   logic [W-1:0] res;
   logic         z;
   logic         c;
   logic         o;
   logic         err;

   // ALU side
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_f;
   logic [W-1:0] alu_s;
   logic         alu_z;
   logic         alu_c;
   logic         alu_o;

   modport slave (
      input  req0, req1, f0, f1, a0, a1, b0, b1,
      output gnt0, gnt1, done0, done1, res, z, c, o, err,
      output alu_a, alu_b, alu_f,
      input  alu_s, alu_z, alu_c, alu_o
   );

   modport master (
      output req0, req1, f0, f1, a0, a1, b0, b1,
      input  gnt0, gnt1, done0, done1, res, z, c, o, err,
      input  alu_a, alu_b, alu_f,
      output alu_s, alu_z, alu_c, alu_o
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter and sequencer for the shared ALU.
// One request is served at a time (IDLE -> EXEC -> RESP); operands are latched
// at grant, the ALU is driven during EXEC and its result is registered for RESP.
module alu_arbiter #(
   parameter int unsigned W = 32
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } state_e;

   state_e       state_q, state_d;

   // Round-robin pointer: the port granted most recently.
   logic         last_q;
   // Port currently being served.
   logic         port_q;

   logic [3:0]   f_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;

   logic         gnt0_q, gnt1_q;
   logic         done0_q, done1_q;
   logic [W-1:0] res_q;
   logic         z_q, c_q, o_q, err_q;

   logic         grant;
   logic         sel;
   logic         in_exec;
   logic         f_ok;

   // Codes the ALU implements; anything else runs as the separator code 0.
   function automatic logic code_valid(input logic [3:0] f);
      case (f)
         4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

   assign in_exec = (state_q == StExec);
   assign f_ok    = code_valid(f_q);

   // Next-state and arbitration decision; requests only matter in IDLE.
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      sel     = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.req0 || bus.req1) begin
               grant   = 1'b1;
               // On conflict the port that did not win last time goes next.
               sel     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
               state_d = StExec;
            end
         end
         StExec:  state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the winning request and advance the round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= 1'b1;
         port_q <= 1'b0;
         f_q    <= 4'd0;
         a_q    <= '0;
         b_q    <= '0;
      end else if (grant) begin
         last_q <= sel;
         port_q <= sel;
         f_q    <= sel ? bus.f1 : bus.f0;
         a_q    <= sel ? bus.a1 : bus.a0;
         b_q    <= sel ? bus.b1 : bus.b0;
      end
   end

   // One-cycle grant and completion pulses to the served port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
      end else begin
         gnt0_q  <= grant & ~sel;
         gnt1_q  <= grant & sel;
         done0_q <= in_exec & ~port_q;
         done1_q <= in_exec & port_q;
      end
   end

   // Capture result and flags at the end of EXEC; hold them until the next completion.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         o_q   <= 1'b0;
         err_q <= 1'b0;
      end else if (in_exec) begin
         if (f_ok) begin
            res_q <= bus.alu_s;
            z_q   <= bus.alu_z;
            c_q   <= bus.alu_c;
            o_q   <= bus.alu_o;
            err_q <= 1'b0;
         end else begin
            res_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            o_q   <= 1'b0;
            err_q <= 1'b1;
         end
      end
   end

   assign bus.gnt0  = gnt0_q;
   assign bus.gnt1  = gnt1_q;
   assign bus.done0 = done0_q;
   assign bus.done1 = done1_q;
   assign bus.res   = res_q;
   assign bus.z     = z_q;
   assign bus.c     = c_q;
   assign bus.o     = o_q;
   assign bus.err   = err_q;

   // Operands keep their last latched values; the code is only presented during EXEC.
   assign bus.alu_a = a_q;
   assign bus.alu_b = b_q;
   assign bus.alu_f = (in_exec && f_ok) ? f_q : 4'd0;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level reference model (grant slots, round robin, expected results).
module tb_alu_arbiter;
   localparam int unsigned W = 32;

   logic clk;
   logic rst_n;

   alu_arbiter_if #(.W(W)) bus ();

   alu_arbiter #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU in the environment; code 0 and other unsupported codes
   // produce a conspicuous junk value so any leak into res is visible.
   function automatic logic [W+2:0] alu_fn(input logic [3:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [W:0]   t;
      logic         ov;
      logic [W:0]   one;
      one = {{W{1'b0}}, 1'b1};
      t   = '0;
      ov  = 1'b0;
      case (f)
         4'd4: begin
            t  = {1'b0, a} + {1'b0, b};
            ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
         end
         4'd5: begin
            t  = {1'b0, a} + {1'b0, ~b} + one;
            ov = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
         end
         4'd6: begin
            t  = {1'b0, ~b} + one;
            ov = (b == {1'b1, {(W-1){1'b0}}});
         end
         4'd7: begin
            t  = {1'b0, b} + one;
            ov = (b == {1'b0, {(W-1){1'b1}}});
         end
         4'd9:  t = {1'b0, a & b};
         4'd10: t = {1'b0, a | b};
         4'd11: t = {1'b0, a ^ b};
         default: return {3'b111, W'(32'hDEAD_BEEF)};
      endcase
      return {ov, t[W], (t[W-1:0] == '0), t[W-1:0]};
   endfunction

   function automatic logic code_ok(input logic [3:0] f);
      return f inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11};
   endfunction

   // Expected completion: {err, o, c, z, res}
   function automatic logic [W+3:0] ref_op(input logic [3:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      if (code_ok(f)) return {1'b0, alu_fn(f, a, b)};
      return {1'b1, {(W+3){1'b0}}};
   endfunction

   always_comb begin
      {bus.alu_o, bus.alu_c, bus.alu_z, bus.alu_s} = alu_fn(bus.alu_f, bus.alu_a, bus.alu_b);
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Requester state
   bit           pend [2];
   logic [3:0]   pf   [2];
   logic [W-1:0] pa   [2];
   logic [W-1:0] pb   [2];
   bit           rand_mode = 1'b0;
   bit           hold_mode = 1'b0;
   logic         rst_req   = 1'b0;

   // Reference model state
   int           free_at = 0;
   int           gnt_at  = -1;
   int           done_at = -1;
   logic         last_m  = 1'b1;
   logic         n_port  = 1'b0;
   logic [3:0]   n_f     = 4'd0;
   logic [W-1:0] n_a     = '0;
   logic [W-1:0] n_b     = '0;
   logic [W+3:0] n_r     = '0;
   logic [W-1:0] h_res   = '0;
   logic         h_z = 1'b0, h_c = 1'b0, h_o = 1'b0, h_err = 1'b0;
   logic [W-1:0] h_a = '0, h_b = '0;

   // Observations for directed tests
   int           gnt_cyc  [2];
   int           done_cyc [2];
   int           done_cnt [2];
   logic [W-1:0] cap_res;
   logic         cap_z, cap_c, cap_o, cap_err;
   logic [3:0]   cap_f;
   int           gq [$];
   logic [W-1:0] rq [$];

   logic [3:0]   vcodes [7] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11};

   function automatic logic [W-1:0] pick_val();
      case ($urandom_range(7))
         0:       return '0;
         1:       return '1;
         2:       return W'(32'h7FFF_FFFF);
         3:       return W'(32'h8000_0000);
         4:       return W'(1);
         default: return W'($urandom);
      endcase
   endfunction

   task automatic new_req(input int k);
      pend[k] = 1'b1;
      pf[k]   = ($urandom_range(9) < 7) ? vcodes[$urandom_range(6)] : 4'($urandom_range(15));
      pa[k]   = pick_val();
      pb[k]   = pick_val();
   endtask

   // One clock cycle: check outputs, react as requesters, predict, drive.
   task automatic step();
      logic s;
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         gnt_at  = -1;
         done_at = -1;
         last_m  = 1'b1;
         free_at = cyc;
         h_res   = '0;
         h_z     = 1'b0;
         h_c     = 1'b0;
         h_o     = 1'b0;
         h_err   = 1'b0;
         h_a     = '0;
         h_b     = '0;
      end
      if (cyc == gnt_at) begin
         h_a = n_a;
         h_b = n_b;
      end
      if (cyc == done_at) begin
         {h_err, h_o, h_c, h_z, h_res} = n_r;
      end
      check_val("gnt0", 32'(bus.gnt0), 32'(cyc == gnt_at && n_port == 1'b0));
      check_val("gnt1", 32'(bus.gnt1), 32'(cyc == gnt_at && n_port == 1'b1));
      check_val("gnt_both", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      check_val("done0", 32'(bus.done0), 32'(cyc == done_at && n_port == 1'b0));
      check_val("done1", 32'(bus.done1), 32'(cyc == done_at && n_port == 1'b1));
      check_val("res", bus.res, h_res);
      check_val("z", 32'(bus.z), 32'(h_z));
      check_val("c", 32'(bus.c), 32'(h_c));
      check_val("o", 32'(bus.o), 32'(h_o));
      check_val("err", 32'(bus.err), 32'(h_err));
      check_val("alu_a", bus.alu_a, h_a);
      check_val("alu_b", bus.alu_b, h_b);
      check_val("alu_f", 32'(bus.alu_f), 32'((cyc == gnt_at && code_ok(n_f)) ? n_f : 4'd0));

      if (bus.gnt0 === 1'b1) begin
         gnt_cyc[0] = cyc;
         gq.push_back(0);
         cap_f = bus.alu_f;
         if (!hold_mode) pend[0] = 1'b0;
      end
      if (bus.gnt1 === 1'b1) begin
         gnt_cyc[1] = cyc;
         gq.push_back(1);
         cap_f = bus.alu_f;
         if (!hold_mode) pend[1] = 1'b0;
      end
      if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
         if (bus.done0 === 1'b1) begin
            done_cnt[0]++;
            done_cyc[0] = cyc;
         end
         if (bus.done1 === 1'b1) begin
            done_cnt[1]++;
            done_cyc[1] = cyc;
         end
         cap_res = bus.res;
         cap_z   = bus.z;
         cap_c   = bus.c;
         cap_o   = bus.o;
         cap_err = bus.err;
         rq.push_back(bus.res);
      end

      for (int k = 0; k < 2; k++) begin
         if (rand_mode && !pend[k] && $urandom_range(2) == 0) new_req(k);
         if (!pend[k]) begin
            pf[k] = 4'($urandom_range(15));
            pa[k] = W'($urandom);
            pb[k] = W'($urandom);
         end
      end

      rst_n = rst_req;
      if (rst_req && cyc >= free_at && (pend[0] || pend[1])) begin
         s       = (pend[0] && pend[1]) ? ~last_m : pend[1];
         last_m  = s;
         n_port  = s;
         n_f     = pf[s];
         n_a     = pa[s];
         n_b     = pb[s];
         n_r     = ref_op(n_f, n_a, n_b);
         gnt_at  = cyc + 1;
         done_at = cyc + 2;
         free_at = cyc + 3;
      end
      bus.req0 = pend[0];
      bus.req1 = pend[1];
      bus.f0   = pf[0];
      bus.f1   = pf[1];
      bus.a0   = pa[0];
      bus.a1   = pa[1];
      bus.b0   = pb[0];
      bus.b1   = pb[1];
   endtask

   task automatic drain();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 30 && !idle; i++) begin
         step();
         idle = !pend[0] && !pend[1] && cyc >= free_at;
      end
      if (!idle) check_val("drain_timeout", 32'd0, 32'd1);
   endtask

   // Issue one request on a quiet arbiter and wait for its completion.
   task automatic run_op(input int port, input logic [3:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      int issue;
      int d0;
      drain();
      pf[port]   = f;
      pa[port]   = a;
      pb[port]   = b;
      pend[port] = 1'b1;
      d0         = done_cnt[port];
      step();
      issue = cyc;
      for (int i = 0; i < 8 && done_cnt[port] == d0; i++) step();
      check_val("op_done_seen", 32'(done_cnt[port] - d0), 32'd1);
      check_val("gnt_latency", 32'(gnt_cyc[port] - issue), 32'd1);
      check_val("done_latency", 32'(done_cyc[port] - issue), 32'd2);
   endtask

   initial begin
      int d0;
      rst_n    = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.f0   = 4'd0;
      bus.f1   = 4'd0;
      bus.a0   = '0;
      bus.a1   = '0;
      bus.b0   = '0;
      bus.b1   = '0;
      for (int k = 0; k < 2; k++) begin
         pend[k]     = 1'b0;
         gnt_cyc[k]  = 0;
         done_cyc[k] = 0;
         done_cnt[k] = 0;
      end

      // Reset state
      rst_req = 1'b0;
      repeat (3) step();
      rst_req = 1'b1;
      step();

      // Single sum
      run_op(0, 4'd4, 32'd6, 32'd7);
      check_val("sum_res", cap_res, 32'd13);
      check_val("sum_flags", 32'({cap_z, cap_c, cap_o, cap_err}), 32'd0);

      // Sub to zero on port 1
      run_op(1, 4'd5, 32'd6, 32'd6);
      check_val("sub_res", cap_res, 32'd0);
      check_val("sub_z", 32'(cap_z), 32'd1);
      check_val("sub_c", 32'(cap_c), 32'd1);

      // Increment overflow
      run_op(0, 4'd7, 32'd0, 32'h7FFF_FFFF);
      check_val("inc_res", cap_res, 32'h8000_0000);
      check_val("inc_o", 32'(cap_o), 32'd1);

      // Unsupported code, then a valid one clears err
      run_op(0, 4'd8, 32'h1234_5678, 32'h0000_00FF);
      check_val("inv_alu_f", 32'(cap_f), 32'd0);
      check_val("inv_res", cap_res, 32'd0);
      check_val("inv_err", 32'(cap_err), 32'd1);
      run_op(1, 4'd11, 32'h0000_00F0, 32'h0000_00FF);
      check_val("xor_res", cap_res, 32'h0000_000F);
      check_val("xor_err", 32'(cap_err), 32'd0);

      // Reset during EXEC on a port-0 request: done dropped, pointer back to 1
      drain();
      pf[0]   = 4'd4;
      pa[0]   = 32'd1;
      pb[0]   = 32'd2;
      pend[0] = 1'b1;
      d0      = done_cnt[0];
      step();
      rst_req = 1'b0;
      step();
      // Both ports request while reset is held: no grant may appear
      hold_mode = 1'b1;
      pf[0] = 4'd9;
      pa[0] = 32'd6;
      pb[0] = 32'd7;
      pf[1] = 4'd10;
      pa[1] = 32'd6;
      pb[1] = 32'd7;
      pend[0] = 1'b1;
      pend[1] = 1'b1;
      step();
      step();
      check_val("rst_done_dropped", 32'(done_cnt[0] - d0), 32'd0);

      // Contention after reset: grants 0,1,0 with results 6 then 7
      gq.delete();
      rq.delete();
      rst_req = 1'b1;
      repeat (12) step();
      check_val("cont_grants", 32'(gq.size() >= 3), 32'd1);
      if (gq.size() >= 3) begin
         check_val("cont_g0", 32'(gq[0]), 32'd0);
         check_val("cont_g1", 32'(gq[1]), 32'd1);
         check_val("cont_g2", 32'(gq[2]), 32'd0);
      end
      check_val("cont_results", 32'(rq.size() >= 2), 32'd1);
      if (rq.size() >= 2) begin
         check_val("cont_r0", rq[0], 32'd6);
         check_val("cont_r1", rq[1], 32'd7);
      end
      hold_mode = 1'b0;
      drain();

      // Randomized traffic with occasional resets
      rand_mode = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         rst_req = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
         step();
      end
      rand_mode = 1'b0;
      rst_req   = 1'b1;
      drain();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared 32-bit ALU. Two requesters (e.g. the datapath control unit and an address-calculation unit) submit operation requests. The block grants one request at a time, drives the ALU from registered operands, and returns the registered result and flags (Z, C, O) to the granted requester. It sits between the requesters and the combinational ALU; the ALU is instantiated outside and connected through the `alu_*` ports.

## Interface

Parameters
- `W`, 32: operand/result width; must match the ALU.

Ports
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `req0`, `req1` in 1: request from port 0 / 1.
- `f0`, `f1` in 4: ALU function code from port 0 / 1.
- `a0`, `a1` in W: operand A from port 0 / 1.
- `b0`, `b1` in W: operand B from port 0 / 1.
- `gnt0`, `gnt1` out 1: one-cycle grant pulse; the request has been accepted.
- `done0`, `done1` out 1: one-cycle completion pulse; `res`/flags/`err` are valid.
- `res` out W: registered result.
- `z`, `c`, `o` out 1: registered ALU flags.
- `err` out 1: the last completed request used an unsupported function code.
- `alu_a`, `alu_b` out W: ALU operands.
- `alu_f` out 4: ALU function code.
- `alu_s` in W: ALU result.
- `alu_z`, `alu_c`, `alu_o` in 1: ALU flags.

## Operation

- States: IDLE, EXEC, RESP. Reset value is IDLE.
- Reset values: all outputs are 0. `alu_f` is 0, the unused separator code. The round-robin pointer `last` is 1, so port 0 wins the first conflict.
- IDLE
  - If neither `req` is high, stay in IDLE.
  - If exactly one `req` is high, select that port.
  - If both are high, select the port that is not `last`.
  - On selection: latch that port's f/a/b, set `last` to the selected port, register the port's `gnt`, and go to EXEC.
- EXEC
  - `alu_a` and `alu_b` carry the latched operands.
  - `alu_f` carries the latched code if it is valid, else 0.
  - At the end of the cycle, capture `res`, `z`, `c`, `o` and `err`, register the port's `done`, and go to RESP.
- RESP: go to IDLE unconditionally. Requests are not sampled in this state.
- Valid codes are 4 (sum), 5 (sub), 6 (two's-complement negate B), 7 (inc B), 9 (and), 10 (or) and 11 (xor).
- Invalid code (any other value):
  - EXEC still occurs, with `alu_f`=0.
  - `res`=0, `z`=`c`=`o`=0, `err`=1.
  - `gnt` and `done` are still issued, with normal latency.
- Flags pass through unmodified from the ALU; the arbiter applies no width rule beyond W.
- `res`, flags and `err` hold their values until the next completion. `err` is cleared by the next valid completion.
- Outside EXEC, `alu_a` and `alu_b` hold their last latched values and `alu_f` is 0.
- Requester rule: hold `req`, f, a and b stable until `gnt` is seen, then drop `req` in the cycle after `gnt` unless issuing a new request. A `req` still high in IDLE is treated as a new request.

## Timing

- Cycle 0: IDLE, `req` sampled at the rising edge that ends the cycle.
- Cycle 1: EXEC, `gnt` high, ALU driven.
- Cycle 2: RESP, `done` high, `res`/flags valid.
- Cycle 3: IDLE, next request sampled.
- Latency from request sample to `done` is 2 cycles. Throughput is 1 operation per 3 cycles.
- At most one of `gnt0`/`gnt1` is high in any cycle, and likewise at most one of `done0`/`done1`.
- With both `req` held continuously, grants alternate 0,1,0,1,…
- Reset asserted mid-operation (EXEC or RESP):
  - The next state is IDLE and all outputs are 0.
  - The pending `done` is dropped.
  - `last` returns to 1.
- Simultaneous request and reset: reset wins, and no grant is issued.

## Test plan

- **Single sum:** `req0`, f0=4, a0=6, b0=7 → `gnt0` in cycle 1, `done0` in cycle 2, `res`=13, z=c=o=0, err=0.
- **Sub to zero:** `req1`, f1=5, a1=6, b1=6 → `done1`, `res`=0, z=1, c=1.
- **Overflow:** `req0`, f0=7, b0=0x7FFFFFFF → `res`=0x80000000, o=1.
- **Contention:** `req0` and `req1` both held with f=9 and f=10, a=6, b=7 → grant order 0,1,0 after reset; results 6 then 7; never both `gnt` high.
- **Invalid code:** `req0`, f0=8 → `alu_f` stays 0 through EXEC, `done0`, `res`=0, err=1. A following valid request clears err.
- **Reset mid-operation:** `rst_n` low in EXEC → no `done` pulse, all outputs 0. The next conflicting request is granted to port 0.
